cache_nway: RTL and testbench
=============================

Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache between the CPU-side memory port and a 256-bit line-granular physical memory port.
- Successor to the fixed 2-way LRU cache.
- Generalises associativity to num_ways, with tree pseudo-LRU replacement and invalid-way-first fill.
- Integrates the word/byte bus adaptation internally.
- Adds saturating hit/miss performance counters.

Parameters:
s_offset, 5, byte-offset bits; line = 2**s_offset bytes; fixed so line = 256 bits
s_index, 3, set-index bits; num_sets = 2**s_index
num_ways, 4, associativity; power of two, >= 2
s_tag, 32-s_offset-s_index, tag bits (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_address  in  32  CPU byte address
mem_read  in  1  CPU read request
mem_write  in  1  CPU write request
mem_byte_enable  in  4  byte mask for mem_wdata
mem_wdata  in  32  CPU write data
mem_rdata  out  32  CPU read data, valid when mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  32  line-aligned physical address
pmem_rdata  in  256  fill line
pmem_wdata  out  256  victim line
pmem_read  out  1  fill request, held until pmem_resp
pmem_write  out  1  write-back request, held until pmem_resp
pmem_resp  in  1  physical memory completion
hit_count  out  32  saturating count of hit completions
miss_count  out  32  saturating count of misses

Behaviour:
- Single clock domain; reset is synchronous and active-high (clk, rst).
- Reset: all valid, dirty and PLRU bits = 0; state IDLE; counters = 0; mem_resp, pmem_read and pmem_write = 0.
- Reset asserted mid-miss aborts the transaction: all pmem requests drop the cycle after rst is sampled; the partial line is discarded.
- Storage is flop-based with combinational read. Per set and way: valid, dirty, tag, 256-bit line. Per set: num_ways-1 PLRU bits.
- Address split: tag = [31:s_offset+s_index]; index = [s_offset+s_index-1:s_offset]; word select = [s_offset-1:2].
- Requester holds address, data, mask and request stable until mem_resp.
- mem_read and mem_write asserted together are treated as a write.
- State IDLE:
  - Request and hit in any way → mem_resp=1 in the same cycle.
  - Read hit: mem_rdata = selected word of the hit way.
  - Write hit: bytes with mem_byte_enable set are merged into the selected word at the clock edge, and dirty is set.
  - Every hit updates PLRU and increments hit_count.
  - Request and miss: increment miss_count once. Choose the victim:
    - the lowest-index invalid way if one exists;
    - otherwise the PLRU victim.
  - Victim valid and dirty → WRITEBACK; otherwise → FETCH.
- State WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line.
  - On pmem_resp → FETCH.
- State FETCH:
  - pmem_read=1; pmem_address = {tag, index, 0}.
  - On pmem_resp: write the line, tag, valid=1 and dirty=0 into the victim way → IDLE. The request then completes as a hit, which counts in hit_count.
- mem_resp is 0 outside IDLE hits.
- Miss latency is the write-back time (if any), plus the fetch time, plus 1 cycle.
- PLRU: a binary tree per set, with node bit 0 meaning the victim lies in the lower-index half.
  - On access to way w, each node on w's path is set to point away from w.
  - On fill, the filled way is treated as accessed.
- Counters saturate at 0xFFFF_FFFF.
- Misses with no request never occur; in IDLE with no request, the cache is idle and does not touch the pmem port.

Test Plan:
1. Reset; read 0x0000_0044 with pmem_rdata word1=0xDEADBEEF → pmem_read with pmem_address 0x40; mem_rdata=0xDEADBEEF; miss_count=1. Repeat the read → 0-cycle hit, no pmem activity, hit_count=2.
2. After 1, write 0x44 with mask 4'b0011 and data 0x1234_5678 → same-cycle mem_resp. A following read of 0x44 returns 0xDEAD_5678.
3. Fill set 2 by reading 0x040, 0x140, 0x240, 0x340, then read 0x440 → victim way 0 (dirty from 2): pmem_write to 0x40 with word1 0xDEAD5678, then pmem_read of 0x440.
4. Fill set 2 as in 3 (clean), touch 0x040, then read 0x440 → victim is way 2 (0x240); no pmem_write; pmem_read 0x440.
5. Assert rst while pmem_read is held in FETCH → pmem_read=0 the next cycle. A subsequent read of the same address misses again; counters read 0 immediately after reset.
6. Assert mem_read and mem_write together on a hit with mask 4'b1111 → treated as a write: data stored, dirty set.

Source files
------------

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache, tree-PLRU replacement, flop storage.
// Latency: hits respond in the request cycle; misses take write-back + fetch + 1 cycle.
// Backpressure: requester holds its request until mem_resp; pmem requests hold until pmem_resp.
module cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  output logic [255:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int num_sets  = 2**s_index;
  localparam int w_bits    = $clog2(num_ways);
  localparam int line_bits = 8 * (2**s_offset);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state, next_state;
  logic [w_bits-1:0] victim;

  logic [num_ways-1:0]  valid [num_sets];
  logic [num_ways-1:0]  dirty [num_sets];
  logic [num_ways-2:0]  plru  [num_sets];
  logic [s_tag-1:0]     tags  [num_sets][num_ways];
  logic [line_bits-1:0] lines [num_sets][num_ways];

  logic [s_tag-1:0]    req_tag;
  logic [s_index-1:0]  idx;
  logic [s_offset-3:0] wsel;
  logic                req;
  logic                hit;
  logic [w_bits-1:0]   hit_way;
  logic [w_bits-1:0]   new_victim;
  logic [w_bits-1:0]   inv_way;
  logic [line_bits-1:0] hit_line;
  logic                unused_bits;

  assign req_tag     = mem_address[31 -: s_tag];
  assign idx         = mem_address[s_offset+s_index-1:s_offset];
  assign wsel        = mem_address[s_offset-1:2];
  assign req         = mem_read | mem_write;
  assign unused_bits = ^mem_address[1:0];

  // Walk the tree: each node bit names the half holding the victim.
  function automatic logic [w_bits-1:0] plru_victim(input logic [num_ways-2:0] t);
    logic [w_bits-1:0] v;
    int n;
    v = '0;
    n = 1;
    for (int l = w_bits - 1; l >= 0; l--) begin
      v[l] = t[n-1];
      n = 2 * n + int'(t[n-1]);
    end
    return v;
  endfunction

  // Point every node on the accessed way's path away from it.
  function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] t,
                                                     input logic [w_bits-1:0] w);
    int n;
    n = 1;
    for (int l = w_bits - 1; l >= 0; l--) begin
      t[n-1] = ~w[l];
      n = 2 * n + int'(w[l]);
    end
    return t;
  endfunction

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (valid[idx][w] && tags[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = w_bits'(w);
      end
    end
  end

  // Victim choice: lowest invalid way first, else the PLRU way.
  always_comb begin
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid[idx][w]) inv_way = w_bits'(w);
    end
    new_victim = (&valid[idx]) ? plru_victim(plru[idx]) : inv_way;
  end

  // Read word mux from the hit way.
  always_comb begin
    hit_line  = lines[idx][hit_way];
    mem_rdata = hit_line[int'(wsel)*32 +: 32];
  end

  // Next-state and port outputs.
  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {req_tag, idx, {s_offset{1'b0}}};
    pmem_wdata   = lines[idx][victim];
    case (state)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
        end else if (req) begin
          next_state = (valid[idx][new_victim] && dirty[idx][new_victim]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[idx][victim], idx, {s_offset{1'b0}}};
        if (pmem_resp) next_state = FETCH;
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, metadata, replacement bits and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      victim     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      state <= next_state;
      if (state == IDLE && req && hit) begin
        plru[idx] <= plru_touch(plru[idx], hit_way);
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        if (mem_write) dirty[idx][hit_way] <= 1'b1;
      end
      if (state == IDLE && req && !hit) begin
        victim <= new_victim;
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
      if (state == FETCH && pmem_resp) begin
        valid[idx][victim] <= 1'b1;
        dirty[idx][victim] <= 1'b0;
        plru[idx]          <= plru_touch(plru[idx], victim);
      end
    end
  end

  // Line and tag storage: byte-merge on write hits, whole-line fill on fetch completion.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && req && hit && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b])
          lines[idx][hit_way][int'(wsel)*32 + b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (!rst && state == FETCH && pmem_resp) begin
      lines[idx][victim] <= pmem_rdata;
      tags[idx][victim]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: behavioural line memory answers pmem requests after 3 cycles.
module tb_cache_nway;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  cache_nway dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  logic [255:0] mem [logic [31:0]];
  int           rd_cnt = 0;
  int           wb_cnt = 0;
  int           wait_cnt = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_line = '0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 8'hA0, 8'(k)};
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Physical memory: responds 3 cycles into any held request.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      pmem_resp = 1'b0;
      if (rst !== 1'b0 || !(pmem_read === 1'b1 || pmem_write === 1'b1)) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          wait_cnt  = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            mem[pmem_address] = pmem_wdata;
            wb_cnt++;
            last_wb_addr = pmem_address;
            last_wb_line = pmem_wdata;
          end else begin
            pmem_rdata = line_of(pmem_address);
            rd_cnt++;
            last_rd_addr = pmem_address;
          end
        end
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata, output int cyc);
    @(negedge clk);
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    cyc = 0;
    rdata = 'x;
    forever begin
      #2;
      if (mem_resp === 1'b1) begin
        rdata = mem_rdata;
        break;
      end
      if (cyc >= 200) begin
        chk("resp_timeout", {31'b0, mem_resp}, 32'd1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]  rdata;
    logic [255:0] tmp;
    int           cyc;
    int           rd0;
    int           wb0;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_byte_enable = '0; mem_wdata = '0;
    tmp = line_of(32'h40);
    tmp[63:32] = 32'hDEADBEEF;
    mem[32'h40] = tmp;

    // 1: cold read miss, then 0-cycle hit
    do_reset();
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    chk("rst_outputs", {29'b0, mem_resp, pmem_read, pmem_write}, 32'd0);
    access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_fill_addr", last_rd_addr, 32'h40);
    chk("t1_latency", 32'(cyc), 32'd4);
    chk("t1_miss_count", miss_count, 32'd1);
    access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t1_hit_latency", 32'(cyc), 32'd0);
    chk("t1_hit_rdata", rdata, 32'hDEADBEEF);
    chk("t1_no_refetch", 32'(rd_cnt), 32'd1);
    chk("t1_hit_count", hit_count, 32'd2);

    // 2: masked write hit, read back
    access(32'h44, 1'b0, 1'b1, 4'b0011, 32'h1234_5678, rdata, cyc);
    chk("t2_wr_latency", 32'(cyc), 32'd0);
    access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t2_merged", rdata, 32'hDEAD_5678);

    // 3: fill set 2, dirty way 0 is evicted
    access(32'h140, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h240, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h340, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    wb0 = wb_cnt;
    access(32'h440, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t3_wb_count", 32'(wb_cnt - wb0), 32'd1);
    chk("t3_wb_addr", last_wb_addr, 32'h40);
    chk("t3_wb_word1", last_wb_line[63:32], 32'hDEAD_5678);
    chk("t3_fill_addr", last_rd_addr, 32'h440);
    chk("t3_latency", 32'(cyc), 32'd7);
    chk("t3_rdata", rdata, 32'h0440_A000);
    chk("t3_miss_count", miss_count, 32'd5);
    chk("t3_hit_count", hit_count, 32'd8);

    // 4: clean fill, touch way 0, PLRU picks way 2
    do_reset();
    chk("t4_rst_miss_count", miss_count, 32'd0);
    access(32'h040, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h140, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h240, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h340, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h040, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t4_touch_hit", 32'(cyc), 32'd0);
    wb0 = wb_cnt;
    access(32'h440, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t4_no_wb", 32'(wb_cnt - wb0), 32'd0);
    chk("t4_fill_addr", last_rd_addr, 32'h440);
    chk("t4_latency", 32'(cyc), 32'd4);
    access(32'h340, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t4_way3_kept", 32'(cyc), 32'd0);
    access(32'h040, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t4_way0_kept", 32'(cyc), 32'd0);
    rd0 = rd_cnt;
    access(32'h240, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t4_way2_evicted", 32'(rd_cnt - rd0), 32'd1);

    // 5: reset while FETCH holds pmem_read
    do_reset();
    @(negedge clk);
    mem_address = 32'h640; mem_read = 1'b1; mem_write = 1'b0;
    cyc = 0;
    forever begin
      #2;
      if (pmem_read === 1'b1 || cyc >= 50) break;
      @(negedge clk);
      cyc++;
    end
    chk("t5_fetch_seen", {31'b0, pmem_read}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    #2;
    chk("t5_pmem_read_dropped", {31'b0, pmem_read}, 32'd0);
    chk("t5_hit_count", hit_count, 32'd0);
    chk("t5_miss_count", miss_count, 32'd0);
    rd0 = rd_cnt;
    access(32'h640, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t5_remiss_latency", 32'(cyc), 32'd4);
    chk("t5_refetch", 32'(rd_cnt - rd0), 32'd1);
    chk("t5_remiss_count", miss_count, 32'd1);

    // 6: read+write together acts as a write and dirties the line
    access(32'h640, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, rdata, cyc);
    chk("t6_rw_latency", 32'(cyc), 32'd0);
    access(32'h640, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t6_rdata", rdata, 32'hCAFE_F00D);
    access(32'h040, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h140, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    access(32'h240, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    wb0 = wb_cnt;
    access(32'h740, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc);
    chk("t6_wb_count", 32'(wb_cnt - wb0), 32'd1);
    chk("t6_wb_addr", last_wb_addr, 32'h640);
    chk("t6_wb_word0", last_wb_line[31:0], 32'hCAFE_F00D);
    chk("t6_miss_count", miss_count, 32'd5);
    chk("t6_hit_count", hit_count, 32'd7);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
